// File: rtl/shift_reg_seq.sv
// Command sequencer for a looping shift register: takes one load/shift command
// per handshake, drives the register control lines, then captures the final q.
module shift_reg_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_d_in,
  output logic             sr_ld,
  output logic             sr_s_cnt,
  output logic             sr_sr,
  output logic             sr_sl,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic             dir_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] data_q;
  logic             abort_flag;

  // Abort gates the control lines in the same cycle so the register never moves.
  always_comb begin
    cmd_ready = (state == IDLE) && rst;
    busy      = (state != IDLE);
    sr_d_in   = data_q;
    sr_ld     = (state == LOAD) && !abort;
    sr_s_cnt  = (state == SHIFT) && !abort;
    sr_sr     = sr_s_cnt && !dir_q;
    sr_sl     = sr_s_cnt && dir_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      remaining  <= '0;
      data_q     <= '0;
      abort_flag <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q      <= cmd_dir;
            remaining  <= cmd_count;
            data_q     <= cmd_data;
            abort_flag <= 1'b0;
            if (cmd_load)
              state <= LOAD;
            else if (cmd_count != '0)
              state <= SHIFT;
            else
              state <= CAPTURE;
          end
        end
        LOAD: begin
          if (abort) begin
            abort_flag <= 1'b1;
            state      <= CAPTURE;
          end else if (remaining != '0) begin
            state <= SHIFT;
          end else begin
            state <= CAPTURE;
          end
        end
        SHIFT: begin
          if (abort) begin
            abort_flag <= 1'b1;
            state      <= CAPTURE;
          end else begin
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE)
              state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The last shift landed at the previous edge, so q is settled here.
          result  <= sr_q;
          done    <= 1'b1;
          aborted <= abort_flag;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Randomized bench for shift_reg_seq: a looping 4-bit register sits on the
// control lines and every command is checked against a rotation-based model.
module tb_shift_reg_seq;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_load = 1'b0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] sr_q = '0;
  logic [WIDTH-1:0] sr_d_in;
  logic             sr_ld;
  logic             sr_s_cnt;
  logic             sr_sr;
  logic             sr_sl;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] ref_q = '0;

  shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .abort(abort), .sr_q(sr_q),
    .sr_d_in(sr_d_in), .sr_ld(sr_ld), .sr_s_cnt(sr_s_cnt), .sr_sr(sr_sr), .sr_sl(sr_sl),
    .busy(busy), .done(done), .aborted(aborted), .result(result)
  );

  always #5 clk = ~clk;

  // The looping shift register being sequenced.
  always @(posedge clk) begin
    if (sr_ld)
      sr_q <= sr_d_in;
    else if (sr_s_cnt && sr_sr)
      sr_q <= {sr_q[0], sr_q[WIDTH-1:1]};
    else if (sr_s_cnt && sr_sl)
      sr_q <= {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
  end

  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] q, input logic dir, input int n);
    logic [2*WIDTH-1:0] dbl;
    int k;
    k = n % WIDTH;
    dbl = {q, q};
    if (!dir) begin
      dbl = dbl >> k;
      return dbl[WIDTH-1:0];
    end else begin
      dbl = dbl << k;
      return dbl[2*WIDTH-1:WIDTH];
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one command end to end; optionally presents the next command in the done cycle.
  task automatic applyStimulus(input logic ld, input logic dir, input logic [CNT_W-1:0] cnt,
                               input logic [WIDTH-1:0] data, input int abort_at, input bit pre_acc,
                               input bit chain, input logic c_ld, input logic c_dir,
                               input logic [CNT_W-1:0] c_cnt, input logic [WIDTH-1:0] c_data);
    int exp_done, shifts, got_done;
    int n_ld, n_sr, n_sl, n_scnt, bad, busy_bad;
    bit exp_ab, ok;
    got_done = 0; n_ld = 0; n_sr = 0; n_sl = 0; n_scnt = 0; bad = 0; busy_bad = 0;
    if (!pre_acc) begin
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin
        @(negedge clk);
        abort = 1'b0;
        cmd_valid = 1'b1; cmd_load = ld; cmd_dir = dir; cmd_count = cnt; cmd_data = data;
        #1;
        ok = cmd_ready;
      end
      checkOutput("accept_ready", 32'(ok), 32'd1);
    end
    exp_ab   = (abort_at > 0);
    shifts   = exp_ab ? abort_at - 1 : int'(cnt);
    exp_done = exp_ab ? int'(ld) + abort_at + 2 : int'(ld) + int'(cnt) + 2;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_load  = 1'($urandom); cmd_dir = 1'($urandom);
      cmd_count = CNT_W'($urandom); cmd_data = WIDTH'($urandom);
      abort = 1'b0;
      if (exp_ab && t == int'(ld) + abort_at)
        abort = 1'b1;
      else if (!exp_ab && t >= exp_done - 1)
        abort = 1'($urandom_range(0, 1));
      if (chain && t == exp_done) begin
        cmd_valid = 1'b1; cmd_load = c_ld; cmd_dir = c_dir; cmd_count = c_cnt; cmd_data = c_data;
      end
      #1;
      n_ld   += int'(sr_ld);
      n_sr   += int'(sr_sr);
      n_sl   += int'(sr_sl);
      n_scnt += int'(sr_s_cnt);
      if ((sr_sr && sr_sl) || (sr_ld && sr_s_cnt) || ((sr_sr || sr_sl) && !sr_s_cnt) || sr_d_in !== data)
        bad++;
      if (done === busy)
        busy_bad++;
      if (done === 1'b1) begin
        got_done = t;
        break;
      end
    end
    if (!chain) begin
      abort = 1'b0;
      cmd_valid = 1'b0;
    end
    if (ld) ref_q = data;
    ref_q = rotate(ref_q, dir, shifts);
    checkOutput("done_cycle", 32'(got_done), 32'(exp_done));
    checkOutput("result", 32'(result), 32'(ref_q));
    checkOutput("aborted", 32'(aborted), 32'(exp_ab));
    checkOutput("ld_pulses", 32'(n_ld), 32'(ld));
    checkOutput("sr_pulses", 32'(n_sr), dir ? 32'd0 : 32'(shifts));
    checkOutput("sl_pulses", 32'(n_sl), dir ? 32'(shifts) : 32'd0);
    checkOutput("scnt_pulses", 32'(n_scnt), 32'(shifts));
    checkOutput("line_invariants", 32'(bad), 32'd0);
    checkOutput("busy_profile", 32'(busy_bad), 32'd0);
    if (chain)
      checkOutput("b2b_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Pulls reset low in the middle of a 5-shift command and checks recovery.
  task automatic resetMidShift();
    int n_done;
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      abort = 1'b0;
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dir = 1'($urandom);
      cmd_count = CNT_W'(5); cmd_data = WIDTH'($urandom);
      #1;
      ok = cmd_ready;
    end
    checkOutput("rst_accept", 32'(ok), 32'd1);
    repeat (2) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_outputs_zero",
                32'({sr_ld, sr_s_cnt, sr_sr, sr_sl, busy, done, aborted, cmd_ready, result, sr_d_in}),
                32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_release_ready", 32'(cmd_ready), 32'd1);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      n_done += int'(done);
    end
    checkOutput("rst_no_done", 32'(n_done), 32'd0);
  endtask

  initial begin
    bit pend, chain;
    logic p_ld, p_dir, n_ld, n_dir;
    logic [CNT_W-1:0] p_cnt, n_cnt;
    logic [WIDTH-1:0] p_data, n_data;
    int p_ab, n_ab;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_d_in", 32'(sr_d_in), 32'd0);
    checkOutput("reset_lines", 32'({sr_ld, sr_s_cnt, sr_sr, sr_sl, aborted}), 32'd0);
    rst = 1'b1;

    applyStimulus(1'b1, 1'b0, 4'd2, 4'b1000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd3, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'b0110, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd7, 4'b1010, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b1, 4'd2, 4'b0011, 0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'b1001);
    applyStimulus(1'b1, 1'b0, 4'd3, 4'b1001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b1, 4'd15, 4'b1100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    pend = 1'b0;
    p_ld = 1'b0; p_dir = 1'b0; p_cnt = '0; p_data = '0; p_ab = 0;
    for (int i = 0; i < 20; i++) begin
      if (!pend) begin
        p_ld = 1'($urandom); p_dir = 1'($urandom);
        p_cnt = CNT_W'($urandom_range(0, 15)); p_data = WIDTH'($urandom);
        p_ab = (p_cnt != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(p_cnt))) : 0;
      end
      chain = (i < 19) && ($urandom_range(0, 1) == 1);
      n_ld = 1'($urandom); n_dir = 1'($urandom);
      n_cnt = CNT_W'($urandom_range(0, 15)); n_data = WIDTH'($urandom);
      n_ab = (n_cnt != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(n_cnt))) : 0;
      applyStimulus(p_ld, p_dir, p_cnt, p_data, p_ab, pend, chain, n_ld, n_dir, n_cnt, n_data);
      pend = chain;
      p_ld = n_ld; p_dir = n_dir; p_cnt = n_cnt; p_data = n_data; p_ab = n_ab;
    end

    resetMidShift();
    applyStimulus(1'b1, 1'b1, 4'd1, 4'b0101, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
